// File: rtl/riscv_mem.sv
// Memory-access pipeline stage: issues load/store requests on a req/ack data port,
// stalls upstream while an access is outstanding, and produces registered writeback.
module riscv_mem #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [4:0]  rd_in,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic        is_load,
  input  logic        is_store,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [4:0]  rd,
  output logic [31:0] wb_data,
  output logic        wb_en,
  output logic        exception
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_reg, state_next;
  logic        req_reg, req_next, we_reg, we_next;
  logic [31:0] addr_reg, addr_next, wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;
  logic [4:0]  rd_reg, rd_next, rd_pend_reg, rd_pend_next;
  logic [31:0] wb_data_reg, wb_data_next;
  logic        wb_en_reg, wb_en_next, exc_reg, exc_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [2:0]  f3_reg, f3_next;
  logic        ld_reg, ld_next;
  logic [1:0]  off_reg, off_next;

  logic        is_mem, f3_ok, align_ok, legal;
  logic [3:0]  sb_strb, st_strb;
  logic [31:0] st_data, rshift, load_val;
  logic [15:0] half;

  assign is_mem = is_load | is_store;

  always_comb begin
    f3_ok = is_load ? (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                    : (funct3 inside {3'd0, 3'd1, 3'd2});
    case (funct3[1:0])
      2'b01:   align_ok = ~result[0];
      2'b10:   align_ok = (result[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal = (is_load ^ is_store) & f3_ok & align_ok;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sb_lane
      assign sb_strb[gi] = (result[1:0] == 2'(gi));
    end
  endgenerate

  always_comb begin
    case (funct3[1:0])
      2'b00:   begin st_strb = sb_strb;                          st_data = {4{store_data[7:0]}};  end
      2'b01:   begin st_strb = result[1] ? 4'b1100 : 4'b0011;    st_data = {2{store_data[15:0]}}; end
      default: begin st_strb = 4'b1111;                          st_data = store_data;            end
    endcase
  end

  // Lane select uses the byte offset captured at issue, since dmem_addr is word-aligned.
  assign rshift = dmem_rdata >> {off_reg, 3'b000};
  assign half   = off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (f3_reg)
      3'd0:    load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'd1:    load_val = {{16{half[15]}}, half};
      3'd4:    load_val = {24'd0, rshift[7:0]};
      3'd5:    load_val = {16'd0, half};
      default: load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    req_next     = req_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    rd_next      = rd_reg;
    rd_pend_next = rd_pend_reg;
    wb_data_next = wb_data_reg;
    cnt_next     = cnt_reg;
    f3_next      = f3_reg;
    ld_next      = ld_reg;
    off_next     = off_reg;
    wb_en_next   = 1'b0;
    exc_next     = 1'b0;
    stall        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid) begin
          if (!is_mem) begin
            rd_next      = rd_in;
            wb_data_next = result;
            wb_en_next   = (rd_in != 5'd0);
          end else if (legal) begin
            stall        = 1'b1;
            req_next     = 1'b1;
            we_next      = is_store;
            addr_next    = {result[31:2], 2'b00};
            wdata_next   = st_data;
            wstrb_next   = is_store ? st_strb : 4'b0000;
            cnt_next     = 8'd0;
            f3_next      = funct3;
            ld_next      = is_load;
            off_next     = result[1:0];
            rd_pend_next = rd_in;
            state_next   = WAIT;
          end else begin
            exc_next = 1'b1;
            rd_next  = rd_in;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          req_next   = 1'b0;
          state_next = IDLE;
          if (ld_reg) begin
            rd_next      = rd_pend_reg;
            wb_data_next = load_val;
            wb_en_next   = (rd_pend_reg != 5'd0);
          end
        end else begin
          stall = 1'b1;
          if (cnt_reg == 8'(TIMEOUT - 1)) begin
            req_next   = 1'b0;
            exc_next   = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      req_reg     <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rd_reg      <= '0;
      rd_pend_reg <= '0;
      wb_data_reg <= '0;
      wb_en_reg   <= 1'b0;
      exc_reg     <= 1'b0;
      cnt_reg     <= '0;
      f3_reg      <= '0;
      ld_reg      <= 1'b0;
      off_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      req_reg     <= req_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      rd_reg      <= rd_next;
      rd_pend_reg <= rd_pend_next;
      wb_data_reg <= wb_data_next;
      wb_en_reg   <= wb_en_next;
      exc_reg     <= exc_next;
      cnt_reg     <= cnt_next;
      f3_reg      <= f3_next;
      ld_reg      <= ld_next;
      off_reg     <= off_next;
    end
  end

  assign dmem_req   = req_reg;
  assign dmem_we    = we_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = wdata_reg;
  assign dmem_wstrb = wstrb_reg;
  assign rd         = rd_reg;
  assign wb_data    = wb_data_reg;
  assign wb_en      = wb_en_reg;
  assign exception  = exc_reg;

endmodule

// File: tb/tb_riscv_mem.sv
// Scoreboard bench for riscv_mem: stimulus pushes expected writeback/exception events and
// memory requests; monitors pop and compare whenever the DUT presents them.
module tb_riscv_mem;

  logic        clk = 1'b0;
  logic        rst, valid, is_load, is_store, dmem_ack;
  logic [4:0]  rd_in;
  logic [31:0] result, store_data, dmem_rdata;
  logic [2:0]  funct3;
  logic        stall, dmem_req, dmem_we, wb_en, exception;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  rd;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_exc;
    bit          chk_rd;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  ev_t  exp_q[$];
  req_t req_q[$];
  logic prev_req = 1'b0;

  riscv_mem #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .valid(valid), .rd_in(rd_in), .result(result),
    .store_data(store_data), .funct3(funct3), .is_load(is_load), .is_store(is_store),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .rd(rd), .wb_data(wb_data), .wb_en(wb_en), .exception(exception)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Writeback / exception monitor
  always @(negedge clk) begin
    if (!rst && (wb_en || exception)) begin
      ev_t e;
      if (wb_en && exception) begin
        tests++; fails++;
        $display("FAIL wb_exc_both: wb_en and exception both high");
      end else if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_event: wb_en=%0b exception=%0b rd=%0d data=%h",
                 wb_en, exception, rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_exc", {31'd0, exception}, {31'd0, e.is_exc});
        if (e.chk_rd) chk("event_rd", {27'd0, rd}, {27'd0, e.rd});
        if (!e.is_exc) chk("event_wb_data", wb_data, e.data);
        $display("[TB] event %s rd=%0d data=%h", exception ? "exception" : "writeback", rd, wb_data);
      end
    end
  end

  // Memory request monitor: compares each new request
  always @(negedge clk) begin
    if (!rst && dmem_req && !prev_req) begin
      req_t r;
      if (req_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_req: addr=%h we=%0b", dmem_addr, dmem_we);
      end else begin
        r = req_q.pop_front();
        chk("req_we", {31'd0, dmem_we}, {31'd0, r.we});
        chk("req_addr", dmem_addr, r.addr);
        if (r.we) chk("req_wdata", dmem_wdata, r.wdata);
        chk("req_wstrb", {28'd0, dmem_wstrb}, {28'd0, r.wstrb});
        $display("[TB] request we=%0b addr=%h wdata=%h wstrb=%b", dmem_we, dmem_addr, dmem_wdata, dmem_wstrb);
      end
    end
    prev_req <= rst ? 1'b0 : dmem_req;
  end

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [4:0] rdi, input logic [31:0] res, input logic [31:0] sd);
    valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    rd_in = rdi; result = res; store_data = sd;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic alu_op(input logic [4:0] rdi, input logic [31:0] res);
    if (rdi != 5'd0) exp_q.push_back('{is_exc: 1'b0, chk_rd: 1'b1, rd: rdi, data: res});
    drive(1'b0, 1'b0, 3'd0, rdi, res, 32'd0);
    @(negedge clk) chk("alu_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("alu_wb_en", {31'd0, wb_en}, {31'd0, (rdi != 5'd0)});
    chk("alu_rd", {27'd0, rd}, {27'd0, rdi});
    @(negedge clk) chk("alu_stall_after", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Legal memory op; acknowledged ack_delay cycles after the request appears.
  task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [4:0] rdi,
                        input logic [31:0] res, input logic [31:0] sd,
                        input logic [31:0] rdata, input int ack_delay,
                        input req_t r, input logic [31:0] exp_data);
    req_q.push_back(r);
    if (ld && rdi != 5'd0) exp_q.push_back('{is_exc: 1'b0, chk_rd: 1'b1, rd: rdi, data: exp_data});
    drive(ld, ~ld, f3, rdi, res, sd);
    @(negedge clk) chk("mem_stall_issue", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk) chk("mem_stall_wait", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(negedge clk) chk("mem_stall_ack", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("mem_req_dropped", {31'd0, dmem_req}, 32'd0);
    chk("mem_exc", {31'd0, exception}, 32'd0);
    if (!ld) chk("store_wb_en", {31'd0, wb_en}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic illegal_op(input logic ld, input logic [2:0] f3, input logic [4:0] rdi,
                            input logic [31:0] res);
    exp_q.push_back('{is_exc: 1'b1, chk_rd: 1'b1, rd: rdi, data: 32'd0});
    drive(ld, ~ld, f3, rdi, res, 32'hDEAD_BEEF);
    @(negedge clk) chk("illegal_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("illegal_req", {31'd0, dmem_req}, 32'd0);
    chk("illegal_exc", {31'd0, exception}, 32'd1);
    @(negedge clk) chk("illegal_stall_after", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
    rd_in = '0; result = '0; store_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_exc", {31'd0, exception}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    alu_op(5'd5, 32'd42);
    alu_op(5'd0, 32'd77);
    chk("x0_wb_data", wb_data, 32'd77);

    // LB / LBU at byte 3 of 0x80FFFFFF
    mem_op(1'b1, 3'd0, 5'd7, 32'h103, 32'd0, 32'h80FF_FFFF, 1,
           '{we: 1'b0, addr: 32'h100, wdata: 32'd0, wstrb: 4'b0000}, 32'hFFFF_FF80);
    mem_op(1'b1, 3'd4, 5'd8, 32'h103, 32'd0, 32'h80FF_FFFF, 1,
           '{we: 1'b0, addr: 32'h100, wdata: 32'd0, wstrb: 4'b0000}, 32'h0000_0080);
    // LH / LHU upper half
    mem_op(1'b1, 3'd1, 5'd9, 32'h102, 32'd0, 32'h8001_1234, 2,
           '{we: 1'b0, addr: 32'h100, wdata: 32'd0, wstrb: 4'b0000}, 32'hFFFF_8001);
    mem_op(1'b1, 3'd5, 5'd10, 32'h102, 32'd0, 32'h8001_1234, 0,
           '{we: 1'b0, addr: 32'h100, wdata: 32'd0, wstrb: 4'b0000}, 32'h0000_8001);
    // LW
    mem_op(1'b1, 3'd2, 5'd11, 32'h44, 32'd0, 32'hCAFE_F00D, 1,
           '{we: 1'b0, addr: 32'h44, wdata: 32'd0, wstrb: 4'b0000}, 32'hCAFE_F00D);
    // Stores: SH upper, SB lane 1, SW
    mem_op(1'b0, 3'd1, 5'd3, 32'h22, 32'h1234_ABCD, 32'd0, 1,
           '{we: 1'b1, addr: 32'h20, wdata: 32'hABCD_ABCD, wstrb: 4'b1100}, 32'd0);
    mem_op(1'b0, 3'd0, 5'd3, 32'h101, 32'h0000_0055, 32'd0, 1,
           '{we: 1'b1, addr: 32'h100, wdata: 32'h5555_5555, wstrb: 4'b0010}, 32'd0);
    mem_op(1'b0, 3'd2, 5'd3, 32'h40, 32'h0102_0304, 32'd0, 1,
           '{we: 1'b1, addr: 32'h40, wdata: 32'h0102_0304, wstrb: 4'b1111}, 32'd0);

    // Misaligned and illegal-funct3 accesses
    illegal_op(1'b1, 3'd2, 5'd12, 32'h6);
    illegal_op(1'b0, 3'd1, 5'd13, 32'h5);
    illegal_op(1'b0, 3'd4, 5'd14, 32'h8);

    // Timeout: no ack for a load
    req_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'd0, wstrb: 4'b0000});
    exp_q.push_back('{is_exc: 1'b1, chk_rd: 1'b0, rd: 5'd0, data: 32'd0});
    drive(1'b1, 1'b0, 3'd2, 5'd15, 32'h300, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (exception) begin n = i; break; end
    end
    chk("timeout_cycles", n, 32'd16);
    chk("timeout_req", {31'd0, dmem_req}, 32'd0);
    chk("timeout_wb_en", {31'd0, wb_en}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("stray_ack_wb_en", {31'd0, wb_en}, 32'd0);
    @(posedge clk); #1;

    // Reset while waiting for an ack
    req_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'd0, wstrb: 4'b0000});
    drive(1'b1, 1'b0, 3'd2, 5'd16, 32'h200, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_wb_en", {31'd0, wb_en}, 32'd0);
    alu_op(5'd6, 32'h0000_1234);

    repeat (2) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("req_q_empty", req_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_mem.md
Name: riscv_mem

Overview:
- Memory-access pipeline stage sitting directly downstream of the execute stage.
- Consumes the EX result (effective address or ALU value) and destination register index, and performs load/store transactions on a data-memory port using a req/ack handshake.
- Produces registered writeback data, the register index and an enable for the writeback stage.
- Stalls upstream stages while a memory transaction is outstanding.

Parameters:
TIMEOUT, 16, max cycles in WAIT without dmem_ack before the access is aborted with an exception (2..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
valid  input  1  EX output holds a live instruction this cycle
rd_in  input  5  destination register index from EX
result  input  32  EX result: effective address for loads/stores, writeback value otherwise
store_data  input  32  rs2 value for stores
funct3  input  3  width/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU
is_load  input  1  instruction is a load
is_store  input  1  instruction is a store
stall  output  1  combinational; upstream holds its outputs and PC while high
dmem_req  output  1  registered request strobe, held until ack
dmem_we  output  1  1 = write
dmem_addr  output  32  word-aligned address, result with bits [1:0] cleared
dmem_wdata  output  32  store data replicated into byte lanes
dmem_wstrb  output  4  byte write enables
dmem_rdata  input  32  read data, valid with dmem_ack
dmem_ack  input  1  one-cycle completion pulse
rd  output  5  writeback register index
wb_data  output  32  writeback value
wb_en  output  1  writeback enable, one cycle per retired instruction
exception  output  1  one-cycle pulse for a misaligned, illegal or timed-out access

Behaviour:
- Reset (async, any state): state=IDLE; dmem_req, dmem_we, wb_en and exception = 0; rd, wb_data, dmem_addr, dmem_wdata, dmem_wstrb = 0; timeout counter = 0.
- A reset asserted mid-transaction drops dmem_req immediately. A late ack is ignored.
- States are IDLE and WAIT.
- IDLE, valid, non-memory instruction (is_load=is_store=0):
  - Retires in 1 cycle: next edge sets rd=rd_in, wb_data=result, wb_en=(rd_in!=0).
- IDLE, valid, memory instruction, legal:
  - At the edge: dmem_req=1; dmem_we=is_store; addr/wdata/wstrb registered; state=WAIT; counter cleared; wb_en=0.
- Legality rules:
  - Exactly one of is_load/is_store is set.
  - funct3 is legal for the access type: load {0,1,2,4,5}, store {0,1,2}.
  - Alignment: H/HU needs addr[0]=0; W needs addr[1:0]=0.
- Illegal memory instruction in IDLE:
  - No request is issued.
  - Next edge: exception=1, wb_en=0, rd=rd_in. Stays in IDLE. Stall is not raised.
- Store lanes:
  - SB: wstrb=1<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: wstrb=addr[1]?4'b1100:4'b0011, wdata={2{sd[15:0]}}.
  - SW: wstrb=4'b1111, wdata=sd.
  - For loads, wstrb=0.
- WAIT:
  - The counter increments each cycle without ack.
  - Inputs are ignored; upstream holds them because stall=1.
- WAIT, edge with dmem_ack=1:
  - dmem_req=0; state=IDLE.
  - For a load: lane select on the captured addr[1:0], then sign-extend (B,H) or zero-extend (BU,HU); wb_data = that value; wb_en=(rd!=0).
  - For a store: wb_en=0.
- WAIT, counter reaches TIMEOUT-1 with no ack:
  - Next edge: dmem_req=0, exception=1, wb_en=0, state=IDLE.
  - Ack and timeout in the same cycle: ack wins.
- stall = (IDLE & valid & legal memory op) | (WAIT & ~dmem_ack).
  - Stall drops in the ack cycle, so upstream advances on the same edge that retires the access. Back-to-back memory ops therefore cost 2 cycles minimum.
- dmem_ack seen in IDLE is ignored.
- wb_en and exception are never both 1.
- A cycle with valid=0 in IDLE: wb_en=0, exception=0, other outputs hold.

Test Plan:
- Reset, then valid ADDI result=42, rd_in=5 -> 1 cycle later rd=5, wb_data=42, wb_en=1, stall=0 throughout. Repeat with rd_in=0 -> wb_en=0.
- LB, result=0x103, funct3=0; memory acks 2 cycles after req with rdata=0x80FFFFFF -> dmem_addr=0x100, stall high until the ack cycle, wb_data=0xFFFFFF80, wb_en=1 pulse. Repeat with LBU -> 0x00000080.
- SH, result=0x22, store_data=0x1234ABCD -> dmem_we=1, dmem_addr=0x20, wstrb=1100, wdata=0xABCDABCD; after ack wb_en=0, exception=0.
- LW at 0x6, then SH at 0x5 -> no dmem_req, exception pulse each, stall never high.
- Load with ack withheld, TIMEOUT=16 -> dmem_req drops and exception=1 exactly 16 cycles after entering WAIT; a later stray ack causes no writeback.
- rst asserted while in WAIT -> dmem_req=0 and stall=0 immediately; a following ADDI retires normally.
